postfix_program_encoder: RTL and testbench
==========================================

// Module: postfix_program_encoder
// PURPOSE
//  Writer side of the postfix term-program interface. Converts an infix token stream (operands,
//  operators, parentheses) into the 8-bit postfix code sequence that the term accumulator executes.
//  Uses the shunting-yard algorithm with an internal operator stack.
//  Writes codes sequentially from address 0 into a postfix program RAM, then appends the end code.
// PARAMETERS
//  CODE_WIDTH      8     width of a postfix code / token code
//  PROG_DEPTH      1403  postfix RAM depth in words
//  OP_STACK_DEPTH  16    operator stack entries (parentheses included)
// PORTS
//  clock       in   1                    single clock, all logic on posedge
//  reset       in   1                    synchronous, active-high
//  start       in   1                    pulse; begins new program (ignored unless IDLE/DONE/ERROR)
//  tok_valid   in   1                    token present
//  tok_ready   out  1                    token accepted when tok_valid&tok_ready
//  tok_kind    in   2                    0 operand, 1 operator, 2 lparen, 3 rparen
//  tok_code    in   CODE_WIDTH           operand: full code (type 00/01/11); operator: [2:0]=opcode
//  tok_last    in   1                    marks final token of expression
//  wr_en       out  1                    postfix RAM write strobe
//  wr_addr     out  $clog2(PROG_DEPTH)   write address
//  wr_data     out  CODE_WIDTH           postfix code
//  prog_len    out  $clog2(PROG_DEPTH)   codes written incl. end code, valid with done
//  done        out  1                    held high after end code written, until start
//  error       out  1                    sticky until start or reset
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; op stack empty; wr_addr 0.
//  Operator codes emitted as {2'b10, {CODE_WIDTH-5{1'b0}}, op[2:0]}; opcodes 100 sub, 011 add,
//   010 div, 001 mul, 000 exp; 101-111 illegal -> ERROR. End code = all ones ({CODE_WIDTH{1'b1}}).
//  Precedence: exp 3 (right-assoc); mul/div 2, add/sub 1 (left-assoc).
//  States: IDLE -> (start) ACCEPT; ACCEPT, POP_PREC, POP_PAREN, FLUSH, WRITE_END, DONE, ERROR.
//  ACCEPT: tok_ready=1 only here and only if op stack not full.
//   operand: wr_en=1, wr_data=tok_code at next cycle; stay ACCEPT.
//   operator: -> POP_PREC.
//   lparen: push; stay ACCEPT.
//   rparen: -> POP_PAREN.
//   tok_last on any accepted token: after its handling completes -> FLUSH.
//  POP_PREC: while top is operator with prec>new (or >= and new left-assoc): pop and write it,
//   one code per cycle; else push new op -> ACCEPT (or FLUSH if tok_last).
//  POP_PAREN: pop/write operators until lparen; discard lparen, no write.
//   Empty stack before lparen -> ERROR.
//  FLUSH: pop/write one operator per cycle; lparen encountered -> ERROR; empty -> WRITE_END.
//  WRITE_END: write end code; prog_len = wr_addr+1; -> DONE (done=1).
//  Writes: max one per cycle; wr_addr increments after each write, never wraps.
//   A write needed at wr_addr == PROG_DEPTH-1 that is not the end code -> ERROR without writing.
//  Push onto full op stack: tok_ready held low; a lparen or operator when full and no pop possible
//   -> ERROR.
//  ERROR: tok_ready=0, wr_en=0, error=1; leaves only on start or reset.
//  start while busy (ACCEPT..WRITE_END): ignored.
//  start in DONE/ERROR: clears done/error/prog_len/stack, wr_addr=0, -> ACCEPT next cycle.
//  reset mid-program: immediate return to reset values; partial RAM contents are don't-care.
//  Latency: operand accept -> its write 1 cycle; program of N codes completes in >= N+1 cycles
//   after last token.
// TESTING
//  a + b * c (a=8'h01,b=8'h02,c=8'h03) -> writes 01,02,03,81,83,FF at addr 0..5; prog_len=6; done=1.
//  ( a - b ) / c -> 01,02,84,03,82,FF; no code written for parens.
//  a ^ b ^ c -> 01,02,03,80,80,FF (right-assoc); a - b - c -> 01,02,84,03,84,FF.
//  a + b ) -> error=1 at rparen, no further wr_en; ( a + b with tok_last -> error=1 during FLUSH.
//  OP_STACK_DEPTH+1 nested lparens -> tok_ready low then error=1; PROG_DEPTH overflow -> error, no wrap.
//  reset asserted mid POP_PREC -> next cycle all outputs 0, IDLE; new start encodes a*b -> 01,02,81,FF.

Source files
------------

// File: rtl/postfix_program_encoder_if.sv
// Token-stream and program-RAM write bus of the postfix program encoder.
// The master drives tokens and start; the slave (the encoder) drives the write port and status.
interface postfix_program_encoder_if #(
  parameter int CODE_WIDTH = 8,
  parameter int PROG_DEPTH = 1403
);
  localparam int AW = $clog2(PROG_DEPTH);

  logic                  start;
  logic                  tok_valid;
  logic                  tok_ready;
  logic [1:0]            tok_kind;
  logic [CODE_WIDTH-1:0] tok_code;
  logic                  tok_last;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [CODE_WIDTH-1:0] wr_data;
  logic [AW-1:0]         prog_len;
  logic                  done;
  logic                  error;

  modport master (
    output start, tok_valid, tok_kind, tok_code, tok_last,
    input  tok_ready, wr_en, wr_addr, wr_data, prog_len, done, error
  );

  modport slave (
    input  start, tok_valid, tok_kind, tok_code, tok_last,
    output tok_ready, wr_en, wr_addr, wr_data, prog_len, done, error
  );
endinterface

// File: rtl/postfix_program_encoder.sv
// Shunting-yard encoder: turns an infix token stream into postfix codes written
// sequentially into the program RAM, terminated by the all-ones end code.
module postfix_program_encoder #(
  parameter int CODE_WIDTH     = 8,
  parameter int PROG_DEPTH     = 1403,
  parameter int OP_STACK_DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  postfix_program_encoder_if.slave bus,
  output logic [2:0]               dbg_state
);
  localparam int AW  = $clog2(PROG_DEPTH);
  localparam int IW  = $clog2(OP_STACK_DEPTH);
  localparam int SPW = $clog2(OP_STACK_DEPTH + 1);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(PROG_DEPTH - 1);
  localparam logic [SPW-1:0] FULL_SP   = SPW'(OP_STACK_DEPTH);
  localparam logic [1:0] K_OPERAND = 2'd0, K_OPERATOR = 2'd1, K_LPAREN = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_POP_PREC, S_POP_PAREN, S_FLUSH, S_WRITE_END, S_DONE, S_ERROR
  } state_t;

  state_t state, state_n;

  // Stack entry: {is_lparen, opcode}.
  logic [3:0]            stack [OP_STACK_DEPTH];
  logic [SPW-1:0]        sp, sp_m1;
  logic [IW-1:0]         top_idx;
  logic [3:0]            top;
  logic                  full, nonempty;
  logic [2:0]            pend_op;
  logic                  pend_last;
  logic                  wr_en_q, done_q, error_q;
  logic [AW-1:0]         wr_addr_q, prog_len_q, waddr_next;
  logic [CODE_WIDTH-1:0] wr_data_q, wcode;
  logic                  at_limit, pops_tok, pops_pend;
  logic                  tok_ready, do_write, push, pop, load_pend, clear, set_done;
  logic [3:0]            push_val;

  function automatic logic [1:0] prec(input logic [2:0] op);
    case (op)
      3'b000:         return 2'd3;
      3'b001, 3'b010: return 2'd2;
      default:        return 2'd1;
    endcase
  endfunction

  // Exponent is the only right-associative operator, so equal precedence pops for all others.
  function automatic logic would_pop(input logic ne, input logic [3:0] t, input logic [2:0] op);
    return ne && !t[3] &&
           ((prec(t[2:0]) > prec(op)) || ((prec(t[2:0]) == prec(op)) && (op != 3'b000)));
  endfunction

  function automatic logic [CODE_WIDTH-1:0] op_code(input logic [2:0] op);
    return {2'b10, {(CODE_WIDTH-5){1'b0}}, op};
  endfunction

  assign sp_m1      = sp - 1'b1;
  assign top_idx    = sp_m1[IW-1:0];
  assign nonempty   = (sp != '0);
  assign full       = (sp == FULL_SP);
  assign top        = nonempty ? stack[top_idx] : 4'd0;
  // A write issued last cycle is visible now at wr_addr; the next free slot follows it.
  assign waddr_next = (wr_en_q && (wr_addr_q != LAST_ADDR)) ? wr_addr_q + 1'b1 : wr_addr_q;
  assign at_limit   = (waddr_next == LAST_ADDR);
  assign pops_tok   = would_pop(nonempty, top, bus.tok_code[2:0]);
  assign pops_pend  = would_pop(nonempty, top, pend_op);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Handshake: a token transfers on a cycle where tok_valid && tok_ready. tok_ready is high
  // only in ACCEPT and, when the op stack is full, only for tokens that need no net push slot.
  always_comb begin
    state_n   = state;
    tok_ready = 1'b0;
    do_write  = 1'b0;
    wcode     = '0;
    push      = 1'b0;
    push_val  = 4'd0;
    pop       = 1'b0;
    load_pend = 1'b0;
    clear     = 1'b0;
    set_done  = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          clear   = 1'b1;
          state_n = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        tok_ready = !full || (bus.tok_kind == K_OPERAND) || (bus.tok_kind == 2'd3) ||
                    ((bus.tok_kind == K_OPERATOR) && pops_tok);
        if (bus.tok_valid && !tok_ready) begin
          state_n = S_ERROR;
        end else if (bus.tok_valid) begin
          case (bus.tok_kind)
            K_OPERAND: begin
              if (at_limit) state_n = S_ERROR;
              else begin
                do_write = 1'b1;
                wcode    = bus.tok_code;
                if (bus.tok_last) state_n = S_FLUSH;
              end
            end
            K_OPERATOR: begin
              if (bus.tok_code[2:0] > 3'd4) state_n = S_ERROR;
              else begin
                load_pend = 1'b1;
                state_n   = S_POP_PREC;
              end
            end
            K_LPAREN: begin
              push     = 1'b1;
              push_val = 4'b1000;
              if (bus.tok_last) state_n = S_FLUSH;
            end
            default: begin
              load_pend = 1'b1;
              state_n   = S_POP_PAREN;
            end
          endcase
        end
      end
      S_POP_PREC: begin
        if (pops_pend) begin
          if (at_limit) state_n = S_ERROR;
          else begin
            pop      = 1'b1;
            do_write = 1'b1;
            wcode    = op_code(top[2:0]);
          end
        end else begin
          push     = 1'b1;
          push_val = {1'b0, pend_op};
          state_n  = pend_last ? S_FLUSH : S_ACCEPT;
        end
      end
      S_POP_PAREN: begin
        if (!nonempty) state_n = S_ERROR;
        else if (top[3]) begin
          pop     = 1'b1;
          state_n = pend_last ? S_FLUSH : S_ACCEPT;
        end else if (at_limit) state_n = S_ERROR;
        else begin
          pop      = 1'b1;
          do_write = 1'b1;
          wcode    = op_code(top[2:0]);
        end
      end
      S_FLUSH: begin
        if (!nonempty) state_n = S_WRITE_END;
        else if (top[3] || at_limit) state_n = S_ERROR;
        else begin
          pop      = 1'b1;
          do_write = 1'b1;
          wcode    = op_code(top[2:0]);
        end
      end
      S_WRITE_END: begin
        do_write = 1'b1;
        wcode    = {CODE_WIDTH{1'b1}};
        set_done = 1'b1;
        state_n  = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) stack[sp[IW-1:0]] <= push_val;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sp         <= '0;
      pend_op    <= 3'd0;
      pend_last  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      prog_len_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_en_q <= do_write;
      if (do_write) wr_data_q <= wcode;
      if (load_pend) begin
        pend_op   <= bus.tok_code[2:0];
        pend_last <= bus.tok_last;
      end
      if (clear) begin
        sp         <= '0;
        wr_addr_q  <= '0;
        prog_len_q <= '0;
        done_q     <= 1'b0;
        error_q    <= 1'b0;
      end else begin
        wr_addr_q <= waddr_next;
        if (push)     sp <= sp + 1'b1;
        else if (pop) sp <= sp - 1'b1;
        if (set_done) begin
          done_q     <= 1'b1;
          prog_len_q <= waddr_next + 1'b1;
        end
        if (state_n == S_ERROR) error_q <= 1'b1;
      end
    end
  end

  assign bus.tok_ready = tok_ready;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.prog_len  = prog_len_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_postfix_program_encoder.sv
// Bench for postfix_program_encoder: directed expressions, error cases, limits and random
// infix streams, all checked against a token-level shunting-yard reference model.
module tb_postfix_program_encoder;
  localparam int CW = 8;
  localparam int PD = 1403;
  localparam int SD = 16;
  localparam int AW = $clog2(PD);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  postfix_program_encoder_if #(.CODE_WIDTH(CW), .PROG_DEPTH(PD)) bus();
  logic [2:0] dbg_state;

  postfix_program_encoder #(.CODE_WIDTH(CW), .PROG_DEPTH(PD), .OP_STACK_DEPTH(SD)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  logic [1:0]    tk_kind[$];
  logic [CW-1:0] tk_code[$];
  logic [CW-1:0] exp_q[$];
  int            exp_len;
  bit            exp_err;
  int            exp_addr;
  logic [CW-1:0] exp_c;
  bit            sb_on = 1'b1;
  int            stray_wr;
  int            n_acc;

  // ---------------- scoreboard on the write port ----------------
  always @(negedge clock) begin
    if (bus.wr_en && sb_on) begin
      total++;
      if (bus.error) stray_wr++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected addr=%0d data=%h", bus.wr_addr, bus.wr_data);
      end else begin
        exp_c = exp_q.pop_front();
        if (bus.wr_data !== exp_c || bus.wr_addr !== AW'(exp_addr)) begin
          bad++;
          $display("FAIL write_stream got addr=%0d data=%h want addr=%0d data=%h",
                   bus.wr_addr, bus.wr_data, exp_addr, exp_c);
        end
      end
      exp_addr++;
    end
  end

  // ---------------- reference model ----------------
  function automatic int prec_of(input int op);
    case (op)
      0:       return 3;   // exp
      1, 2:    return 2;   // mul, div
      default: return 1;   // add, sub
    endcase
  endfunction

  function automatic logic [CW-1:0] opc(input int op);
    logic [CW-1:0] c;
    c = 8'h80;
    c[2:0] = op[2:0];
    return c;
  endfunction

  task automatic emit(input logic [CW-1:0] c, input bit is_end);
    if (!is_end && exp_q.size() == PD - 1) exp_err = 1'b1;
    else exp_q.push_back(c);
  endtask

  task automatic model_run();
    int st[$];
    int op;
    exp_q.delete();
    exp_err = 1'b0;
    foreach (tk_kind[i]) begin
      if (exp_err) break;
      case (tk_kind[i])
        2'd0: emit(tk_code[i], 1'b0);
        2'd1: begin
          op = int'(tk_code[i][2:0]);
          if (op > 4) exp_err = 1'b1;
          else begin
            while (!exp_err && st.size() > 0 && st[$] >= 0 &&
                   (prec_of(st[$]) > prec_of(op) || (prec_of(st[$]) == prec_of(op) && op != 0)))
              emit(opc(st.pop_back()), 1'b0);
            if (!exp_err) begin
              if (st.size() == SD) exp_err = 1'b1;
              else st.push_back(op);
            end
          end
        end
        2'd2: begin
          if (st.size() == SD) exp_err = 1'b1;
          else st.push_back(-1);
        end
        default: begin
          while (!exp_err && st.size() > 0 && st[$] >= 0) emit(opc(st.pop_back()), 1'b0);
          if (!exp_err) begin
            if (st.size() == 0) exp_err = 1'b1;
            else void'(st.pop_back());
          end
        end
      endcase
    end
    while (!exp_err && st.size() > 0) begin
      if (st[$] < 0) exp_err = 1'b1;
      else emit(opc(st.pop_back()), 1'b0);
    end
    if (!exp_err) emit({CW{1'b1}}, 1'b1);
    exp_len = exp_q.size();
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_tok(input logic [1:0] k, input logic [CW-1:0] c);
    tk_kind.push_back(k);
    tk_code.push_back(c);
  endtask

  task automatic load_expr(input string s);
    byte ch;
    tk_kind.delete();
    tk_code.delete();
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      case (ch)
        "a": add_tok(2'd0, 8'h01);
        "b": add_tok(2'd0, 8'h02);
        "c": add_tok(2'd0, 8'h03);
        "+": add_tok(2'd1, 8'h03);
        "-": add_tok(2'd1, 8'h04);
        "*": add_tok(2'd1, 8'h01);
        "/": add_tok(2'd1, 8'h02);
        "^": add_tok(2'd1, 8'h00);
        "?": add_tok(2'd1, 8'h05);
        "(": add_tok(2'd2, 8'h00);
        ")": add_tok(2'd3, 8'h00);
        default: ;
      endcase
    end
  endtask

  task automatic gen_random();
    int depth;
    bit want_operand;
    logic [CW-1:0] c;
    tk_kind.delete();
    tk_code.delete();
    depth = 0;
    want_operand = 1'b1;
    while (1) begin
      if (want_operand) begin
        if (depth < 5 && $urandom_range(0, 3) == 0) begin
          add_tok(2'd2, 8'h00);
          depth++;
        end else begin
          c = 8'($urandom_range(0, 255));
          if (c[7:6] == 2'b10) c[7] = 1'b0;
          add_tok(2'd0, c);
          want_operand = 1'b0;
        end
      end else if (depth > 0 && ($urandom_range(0, 9) < 3 || tk_kind.size() > 30)) begin
        add_tok(2'd3, 8'h00);
        depth--;
      end else if (depth == 0 && tk_kind.size() > 12) begin
        break;
      end else begin
        add_tok(2'd1, 8'($urandom_range(0, 4)));
        want_operand = 1'b1;
      end
    end
  endtask

  task automatic pulse_start();
    exp_addr = 0;
    stray_wr = 0;
    n_acc    = 0;
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic send_tok(input logic [1:0] k, input logic [CW-1:0] c, input bit last,
                          output bit ok);
    int budget;
    budget = 50;
    ok = 1'b0;
    bus.tok_valid = 1'b1;
    bus.tok_kind  = k;
    bus.tok_code  = c;
    bus.tok_last  = last;
    while (budget > 0) begin
      #1;
      if (bus.tok_ready) begin
        @(posedge clock);
        @(negedge clock);
        ok = 1'b1;
        break;
      end
      if (bus.error) break;
      @(negedge clock);
      budget--;
    end
    bus.tok_valid = 1'b0;
    bus.tok_last  = 1'b0;
    if (budget == 0) begin
      total++;
      bad++;
      $display("FAIL tok_handshake_timeout got tok_ready=0 for 50 cycles want accept");
    end
  endtask

  task automatic run_expr();
    bit ok;
    int budget;
    model_run();
    pulse_start();
    foreach (tk_kind[i]) begin
      send_tok(tk_kind[i], tk_code[i], i == tk_kind.size() - 1, ok);
      if (!ok) break;
      n_acc++;
    end
    budget = 200;
    while (!bus.done && !bus.error && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (budget == 0) begin
      total++;
      bad++;
      $display("FAIL program_timeout got done=0 error=0 want completion");
    end
    repeat (3) @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start = 1'b0; bus.tok_valid = 1'b0; bus.tok_kind = 2'd0;
    bus.tok_code = '0; bus.tok_last = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.prog_len, bus.done, bus.error, bus.tok_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got en=%b addr=%0d data=%h len=%0d done=%b err=%b rdy=%b want all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.prog_len, bus.done, bus.error, bus.tok_ready);
    end
  endtask

  task automatic test_precedence();
    string exprs[5];
    exprs = '{"a+b*c", "(a-b)/c", "a^b^c", "a-b-c", "a*(b+c)^a-b/c"};
    foreach (exprs[i]) begin
      load_expr(exprs[i]);
      run_expr();
      total++;
      if (exp_q.size() != 0 || bus.done !== 1'b1 || bus.error !== 1'b0) begin
        bad++;
        $display("FAIL prec_%0d got missing=%0d done=%b err=%b want missing=0 done=1 err=0",
                 i, exp_q.size(), bus.done, bus.error);
      end
      total++;
      if (bus.prog_len !== AW'(exp_len)) begin
        bad++;
        $display("FAIL prec_len_%0d got %0d want %0d", i, bus.prog_len, exp_len);
      end
    end
  endtask

  task automatic test_error_cases();
    string exprs[4];
    exprs = '{"a+b)", "(a+b", "a?b", "a*b)+c"};
    foreach (exprs[i]) begin
      load_expr(exprs[i]);
      run_expr();
      total++;
      if (bus.error !== 1'b1 || bus.done !== 1'b0 || exp_q.size() != 0 || stray_wr != 0) begin
        bad++;
        $display("FAIL err_%0d got err=%b done=%b missing=%0d stray=%0d want err=1 done=0 missing=0 stray=0",
                 i, bus.error, bus.done, exp_q.size(), stray_wr);
      end
      total++;
      if (bus.wr_en !== 1'b0 || bus.tok_ready !== 1'b0) begin
        bad++;
        $display("FAIL err_quiet_%0d got wr_en=%b tok_ready=%b want 0 0", i, bus.wr_en, bus.tok_ready);
      end
    end
  endtask

  task automatic test_nesting();
    tk_kind.delete();
    tk_code.delete();
    for (int i = 0; i < SD + 1; i++) add_tok(2'd2, 8'h00);
    add_tok(2'd0, 8'h01);
    run_expr();
    total++;
    if (n_acc != SD || bus.error !== 1'b1 || exp_addr != 0) begin
      bad++;
      $display("FAIL nest_overflow got accepted=%0d err=%b writes=%0d want accepted=%0d err=1 writes=0",
               n_acc, bus.error, exp_addr, SD);
    end
  endtask

  task automatic test_overflow();
    for (int pass = 0; pass < 2; pass++) begin
      tk_kind.delete();
      tk_code.delete();
      for (int i = 0; i < PD - 1 + pass; i++) add_tok(2'd0, 8'($urandom_range(0, 63)));
      run_expr();
      total++;
      if (bus.error !== exp_err || bus.done !== !exp_err || exp_q.size() != 0 || exp_err != (pass == 1)) begin
        bad++;
        $display("FAIL depth_%0d got err=%b done=%b missing=%0d want err=%b done=%b missing=0",
                 pass, bus.error, bus.done, exp_q.size(), pass == 1, pass == 0);
      end
      total++;
      if (pass == 0 ? (bus.prog_len !== AW'(PD)) : (exp_addr != PD - 1)) begin
        bad++;
        $display("FAIL depth_len_%0d got prog_len=%0d writes=%0d want prog_len=%0d writes=%0d",
                 pass, bus.prog_len, exp_addr, PD, PD - 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    sb_on = 1'b0;
    pulse_start();
    load_expr("a*b+");
    foreach (tk_kind[i]) send_tok(tk_kind[i], tk_code[i], 1'b0, ok);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    total++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.prog_len, bus.done, bus.error, bus.tok_ready} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got en=%b addr=%0d data=%h len=%0d done=%b err=%b rdy=%b want all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.prog_len, bus.done, bus.error, bus.tok_ready);
    end
    reset = 1'b0;
    sb_on = 1'b1;
    load_expr("a*b");
    run_expr();
    total++;
    if (exp_q.size() != 0 || bus.done !== 1'b1 || bus.prog_len !== AW'(4)) begin
      bad++;
      $display("FAIL midreset_rerun got missing=%0d done=%b len=%0d want 0 1 4",
               exp_q.size(), bus.done, bus.prog_len);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      gen_random();
      run_expr();
      total++;
      if (exp_q.size() != 0 || bus.done !== 1'b1 || bus.prog_len !== AW'(exp_len)) begin
        bad++;
        $display("FAIL random_%0d got missing=%0d done=%b len=%0d want 0 1 %0d",
                 n, exp_q.size(), bus.done, bus.prog_len, exp_len);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_precedence();
    test_error_cases();
    test_nesting();
    test_reset_mid();
    test_random();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
